sobel_seq: RTL

SOBEL_SEQ -- requirements
Module: sobel_seq

---
 rtl/sobel_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sobel_seq.sv
// Frame sequencer for a 3x3 Sobel datapath: tags each camera pixel with its
// (row, col), flags full windows, drains the pipeline, and reports config/overflow errors.
module sobel_seq #(
    parameter int DRAIN = 2,
    parameter int MAXW  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] width,
    input  logic [12:0] height,
    input  logic [7:0]  pix_in,
    input  logic        pix_in_vld,
    output logic [7:0]  pix_out,
    output logic [12:0] row_out,
    output logic [12:0] col_out,
    output logic        filt_en,
    output logic        win_vld,
    output logic        busy,
    output logic        frame_done,
    output logic        err_cfg,
    output logic        err_ovf,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

    localparam logic [12:0] MAXW_L     = 13'(MAXW);
    localparam logic [12:0] DRAIN_LAST = 13'(DRAIN - 1);

    state_t      state_q, state_d;
    logic [12:0] w_q, w_d, h_q, h_d;
    logic [12:0] row_q, row_d, col_q, col_d;
    logic [7:0]  pix_out_q, pix_out_d;
    logic [12:0] row_out_q, row_out_d, col_out_q, col_out_d;
    logic        filt_en_q, filt_en_d, win_vld_q, win_vld_d;
    logic        busy_q, busy_d, frame_done_q, frame_done_d;
    logic        err_cfg_q, err_cfg_d, err_ovf_q, err_ovf_d;

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        h_d          = h_q;
        row_d        = row_q;
        col_d        = col_q;
        pix_out_d    = 8'd0;
        row_out_d    = row_out_q;
        col_out_d    = col_out_q;
        filt_en_d    = 1'b0;
        win_vld_d    = 1'b0;
        frame_done_d = 1'b0;
        err_cfg_d    = err_cfg_q;
        err_ovf_d    = err_ovf_q;

        case (state_q)
            IDLE: begin
                if (pix_in_vld) err_ovf_d = 1'b1;
                if (start) begin
                    w_d = width;
                    h_d = height;
                    if (width >= 13'd3 && width <= MAXW_L && height >= 13'd3) begin
                        state_d   = ACTIVE;
                        err_cfg_d = 1'b0;
                        err_ovf_d = 1'b0;
                        row_d     = 13'd0;
                        col_d     = 13'd0;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // row_q/col_q always name the coordinate of the next pixel to arrive
                if (pix_in_vld) begin
                    pix_out_d = pix_in;
                    row_out_d = row_q;
                    col_out_d = col_q;
                    filt_en_d = 1'b1;
                    win_vld_d = (row_q >= 13'd2) && (row_q <= h_q - 13'd1) &&
                                (col_q >= 13'd2) && (col_q <= w_q - 13'd1);
                    if (col_q == w_q - 13'd1) begin
                        col_d = 13'd0;
                        if (row_q == h_q - 13'd1) begin
                            row_d   = h_q;
                            state_d = FLUSH;
                        end else begin
                            row_d = row_q + 13'd1;
                        end
                    end else begin
                        col_d = col_q + 13'd1;
                    end
                end
            end
            FLUSH: begin
                // col_q doubles as the drain index while flushing
                if (pix_in_vld) err_ovf_d = 1'b1;
                filt_en_d = 1'b1;
                row_out_d = h_q;
                col_out_d = col_q;
                if (col_q >= DRAIN_LAST) state_d = DONE;
                else                     col_d   = col_q + 13'd1;
            end
            DONE: begin
                if (pix_in_vld) err_ovf_d = 1'b1;
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            w_q          <= 13'd0;
            h_q          <= 13'd0;
            row_q        <= 13'd0;
            col_q        <= 13'd0;
            pix_out_q    <= 8'd0;
            row_out_q    <= 13'd0;
            col_out_q    <= 13'd0;
            filt_en_q    <= 1'b0;
            win_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_cfg_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            h_q          <= h_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pix_out_q    <= pix_out_d;
            row_out_q    <= row_out_d;
            col_out_q    <= col_out_d;
            filt_en_q    <= filt_en_d;
            win_vld_q    <= win_vld_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_cfg_q    <= err_cfg_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign pix_out    = pix_out_q;
    assign row_out    = row_out_q;
    assign col_out    = col_out_q;
    assign filt_en    = filt_en_q;
    assign win_vld    = win_vld_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_cfg    = err_cfg_q;
    assign err_ovf    = err_ovf_q;
    assign state_dbg  = state_q;

endmodule
